// File: rtl/wasm_pkg.sv
// Shared WASM stack-CPU definitions: opcodes, immediate kinds, error codes.
// Used by the fetch/decode front end and by the core.
package wasm_pkg;

    localparam logic [7:0] OP_UNREACHABLE = 8'h00;
    localparam logic [7:0] OP_BLOCK       = 8'h02;
    localparam logic [7:0] OP_LOOP        = 8'h03;
    localparam logic [7:0] OP_IF          = 8'h04;
    localparam logic [7:0] OP_END         = 8'h0B;
    localparam logic [7:0] OP_BR          = 8'h0C;
    localparam logic [7:0] OP_BR_IF       = 8'h0D;
    localparam logic [7:0] OP_CALL        = 8'h10;
    localparam logic [7:0] OP_DROP        = 8'h1A;
    localparam logic [7:0] OP_LOCAL_GET   = 8'h20;
    localparam logic [7:0] OP_GLOBAL_SET  = 8'h24;
    localparam logic [7:0] OP_I32_CONST   = 8'h41;
    localparam logic [7:0] OP_I64_CONST   = 8'h42;
    localparam logic [7:0] OP_NUM_FIRST   = 8'h45;
    localparam logic [7:0] OP_NUM_LAST    = 8'hC4;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_OVF  = 2'd2;
    localparam logic [1:0] ERR_OPC  = 2'd3;

    typedef enum logic [2:0] {
        IMM_KIND_NONE,
        IMM_KIND_U32,
        IMM_KIND_S32,
        IMM_KIND_S64,
        IMM_KIND_BT,
        IMM_KIND_UNK
    } imm_kind_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_OP_REQ,
        S_OP_REL,
        S_IMM_REQ,
        S_IMM_REL,
        S_DONE,
        S_ERR
    } fd_state_e;

    function automatic imm_kind_e imm_kind(input logic [7:0] op);
        imm_kind_e k;
        unique case (1'b1)
            op == OP_UNREACHABLE,
            op == OP_END,
            op == OP_DROP,
            (op >= OP_NUM_FIRST && op <= OP_NUM_LAST):
                k = IMM_KIND_NONE;
            op == OP_BR,
            op == OP_BR_IF,
            op == OP_CALL,
            (op >= OP_LOCAL_GET && op <= OP_GLOBAL_SET):
                k = IMM_KIND_U32;
            op == OP_I32_CONST:
                k = IMM_KIND_S32;
            op == OP_I64_CONST:
                k = IMM_KIND_S64;
            (op >= OP_BLOCK && op <= OP_IF):
                k = IMM_KIND_BT;
            default:
                k = IMM_KIND_UNK;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/wasm_fetch_decode_leb128_accum.sv
// LEB128 accumulator: folds one byte per byte_valid into value, tracking
// length, termination and final-byte range checks.
module leb128_accum #(
    parameter int IMM_W  = 64,
    parameter bit STRICT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             byte_valid,
    input  logic [7:0]       byte_in,
    input  logic             is_signed,
    input  logic [3:0]       max_bytes,
    output logic [IMM_W-1:0] value,
    output logic [3:0]       count,
    output logic             last,
    output logic             err_len,
    output logic             err_ovf
);

    logic [IMM_W-1:0] value_q, value_d;
    logic [3:0]       count_q, count_d;
    logic             last_q, last_d;
    logic             err_len_q, err_len_d;
    logic             err_ovf_q, err_ovf_d;

    logic [IMM_W-1:0] fill;
    logic             fin, at_max, bad_top;
    int               shamt, nbits;

    always_comb begin
        value_d   = value_q;
        count_d   = count_q;
        last_d    = last_q;
        err_len_d = err_len_q;
        err_ovf_d = err_ovf_q;
        shamt     = 7 * int'(count_q);
        nbits     = shamt + 7;
        fin       = ~byte_in[7];
        at_max    = (count_q + 4'd1) == max_bytes;
        fill      = '0;
        // payload bits of the final byte that fall outside the target width
        if (max_bytes == 4'd10)
            bad_top = is_signed ? (byte_in[6:1] != {6{byte_in[0]}})
                                : (byte_in[6:1] != 6'd0);
        else
            bad_top = is_signed ? (byte_in[6:3] != {4{byte_in[3]}})
                                : (byte_in[6:4] != 3'd0);
        if (is_signed && fin && byte_in[6] && nbits < IMM_W)
            fill = {IMM_W{1'b1}} << nbits;
        if (clear) begin
            value_d   = '0;
            count_d   = '0;
            last_d    = 1'b0;
            err_len_d = 1'b0;
            err_ovf_d = 1'b0;
        end else if (byte_valid) begin
            value_d   = value_q | (IMM_W'(byte_in[6:0]) << shamt) | fill;
            count_d   = count_q + 4'd1;
            last_d    = fin;
            err_len_d = ~fin & at_max;
            err_ovf_d = STRICT & fin & at_max & bad_top;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q   <= '0;
            count_q   <= '0;
            last_q    <= 1'b0;
            err_len_q <= 1'b0;
            err_ovf_q <= 1'b0;
        end else begin
            value_q   <= value_d;
            count_q   <= count_d;
            last_q    <= last_d;
            err_len_q <= err_len_d;
            err_ovf_q <= err_ovf_d;
        end
    end

    assign value   = value_q;
    assign count   = count_q;
    assign last    = last_q;
    assign err_len = err_len_q;
    assign err_ovf = err_ovf_q;

endmodule

// File: rtl/wasm_fetch_decode.sv
// WASM fetch/decode front end: fetches an opcode and its immediate
// byte by byte over a req/release memory handshake.
module wasm_fetch_decode
    import wasm_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int IMM_W  = 64,
    parameter bit STRICT = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_pc,
    output logic              busy,
    output logic              done,
    output logic [7:0]        opcode,
    output logic [IMM_W-1:0]  imm,
    output logic [3:0]        imm_bytes,
    output logic [ADDR_W-1:0] next_pc,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read_en,
    input  logic              mem_ready,
    input  logic [7:0]        mem_data
);

    fd_state_e         state_q, state_d;
    imm_kind_e         kind_q;
    logic [ADDR_W-1:0] pc_q, next_pc_q;
    logic [7:0]        opcode_q, bt_q;
    logic              bt_seen_q, armed_q;
    logic [1:0]        err_code_q;

    logic             capture, imm_err, acc_clear, acc_valid;
    logic [IMM_W-1:0] acc_value;
    logic [3:0]       acc_count;
    logic             acc_last, acc_err_len, acc_err_ovf;

    // a ready left high from a previous beat must drop before it counts
    assign capture   = mem_ready & armed_q;
    assign imm_err   = acc_err_len | acc_err_ovf;
    assign acc_clear = (state_q == S_IDLE) & start;
    assign acc_valid = (state_q == S_IMM_REQ) & capture
                     & (kind_q != IMM_KIND_BT);

    leb128_accum #(
        .IMM_W  (IMM_W),
        .STRICT (STRICT)
    ) u_leb (
        .clk        (clk),
        .rst        (rst),
        .clear      (acc_clear),
        .byte_valid (acc_valid),
        .byte_in    (mem_data),
        .is_signed  ((kind_q == IMM_KIND_S32) | (kind_q == IMM_KIND_S64)),
        .max_bytes  ((kind_q == IMM_KIND_S64) ? 4'd10 : 4'd5),
        .value      (acc_value),
        .count      (acc_count),
        .last       (acc_last),
        .err_len    (acc_err_len),
        .err_ovf    (acc_err_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (start) state_d = S_OP_REQ;
            S_OP_REQ:  if (capture) state_d = S_OP_REL;
            S_OP_REL:
                if (!mem_ready) begin
                    if (kind_q == IMM_KIND_UNK)       state_d = S_ERR;
                    else if (kind_q == IMM_KIND_NONE) state_d = S_DONE;
                    else                              state_d = S_IMM_REQ;
                end
            S_IMM_REQ: if (capture) state_d = S_IMM_REL;
            S_IMM_REL:
                if (!mem_ready) begin
                    if (imm_err)                   state_d = S_ERR;
                    else if (kind_q == IMM_KIND_BT) state_d = S_DONE;
                    else if (acc_last)             state_d = S_DONE;
                    else                           state_d = S_IMM_REQ;
                end
            S_DONE:    state_d = S_IDLE;
            S_ERR:     state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        error       = 1'b0;
        mem_read_en = 1'b0;
        unique case (state_q)
            S_OP_REQ, S_IMM_REQ: begin
                busy        = 1'b1;
                mem_read_en = 1'b1;
            end
            S_OP_REL, S_IMM_REL: busy = 1'b1;
            S_DONE:              done = 1'b1;
            S_ERR:               error = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= '0;
            next_pc_q  <= '0;
            opcode_q   <= '0;
            kind_q     <= IMM_KIND_NONE;
            bt_q       <= '0;
            bt_seen_q  <= 1'b0;
            armed_q    <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            if (acc_clear) begin
                pc_q       <= start_pc;
                opcode_q   <= '0;
                kind_q     <= IMM_KIND_NONE;
                bt_q       <= '0;
                bt_seen_q  <= 1'b0;
                err_code_q <= ERR_NONE;
                armed_q    <= ~mem_ready;
            end
            if (mem_read_en && !mem_ready) armed_q <= 1'b1;
            if (mem_read_en && capture)    armed_q <= 1'b0;
            if (state_q == S_OP_REQ && capture) begin
                opcode_q <= mem_data;
                kind_q   <= imm_kind(mem_data);
            end
            if (state_q == S_IMM_REQ && capture && kind_q == IMM_KIND_BT) begin
                bt_q      <= mem_data;
                bt_seen_q <= 1'b1;
            end
            if (state_d == S_IMM_REQ && state_q != S_IMM_REQ) begin
                pc_q    <= pc_q + ADDR_W'(1);
                armed_q <= 1'b1;
            end
            if (state_d == S_DONE)
                next_pc_q <= pc_q + ADDR_W'(1);
            if (state_d == S_ERR) begin
                next_pc_q <= pc_q;
                if (kind_q == IMM_KIND_UNK) err_code_q <= ERR_OPC;
                else if (acc_err_len)       err_code_q <= ERR_LEN;
                else                        err_code_q <= ERR_OVF;
            end
        end
    end

    assign mem_addr  = pc_q;
    assign opcode    = opcode_q;
    assign next_pc   = next_pc_q;
    assign err_code  = err_code_q;
    assign imm       = (kind_q == IMM_KIND_BT) ? IMM_W'(bt_q) : acc_value;
    assign imm_bytes = (kind_q == IMM_KIND_BT) ? {3'b000, bt_seen_q}
                                               : acc_count;

endmodule

// File: tb/tb_wasm_fetch_decode.sv
// Bench for wasm_fetch_decode: directed decodes, reset mid-fetch and
// random programs against a byte-level reference model.
module tb_wasm_fetch_decode;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [31:0] start_pc;
    logic        busy, done, error, mem_read_en, mem_ready;
    logic [7:0]  opcode, mem_data;
    logic [63:0] imm;
    logic [3:0]  imm_bytes;
    logic [31:0] next_pc, mem_addr;
    logic [1:0]  err_code;

    always #5 clk = ~clk;

    wasm_fetch_decode dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .start_pc    (start_pc),
        .busy        (busy),
        .done        (done),
        .opcode      (opcode),
        .imm         (imm),
        .imm_bytes   (imm_bytes),
        .next_pc     (next_pc),
        .error       (error),
        .err_code    (err_code),
        .mem_addr    (mem_addr),
        .mem_read_en (mem_read_en),
        .mem_ready   (mem_ready),
        .mem_data    (mem_data)
    );

    // memory: 256 bytes aliased over the address space
    logic [7:0] mem [256];
    int lat_fixed = 0;
    int lat_rand  = 0;
    bit rand_lat  = 1'b0;
    int cnt       = 0;
    int lat_eff;

    assign lat_eff   = rand_lat ? lat_rand : lat_fixed;
    assign mem_data  = mem[mem_addr[7:0]];
    assign mem_ready = mem_read_en && (cnt >= lat_eff);

    always @(posedge clk) begin
        if (!mem_read_en) begin
            cnt      <= 0;
            lat_rand <= int'($urandom_range(0, 5));
        end else begin
            cnt <= cnt + 1;
        end
    end

    int checks = 0;
    int fails  = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        bit          err;
        logic [1:0]  code;
        logic [7:0]  op;
        logic [63:0] imm;
        int          nb;
        logic [31:0] npc;
    } exp_t;

    // 0 none, 1 u32, 2 s32, 3 s64, 4 raw byte, 5 unknown
    function automatic int kind_of(input logic [7:0] op);
        if (op == 8'h00 || op == 8'h0B || op == 8'h1A ||
            (op >= 8'h45 && op <= 8'hC4)) return 0;
        if (op == 8'h0C || op == 8'h0D || op == 8'h10 ||
            (op >= 8'h20 && op <= 8'h24)) return 1;
        if (op == 8'h41) return 2;
        if (op == 8'h42) return 3;
        if (op >= 8'h02 && op <= 8'h04) return 4;
        return 5;
    endfunction

    function automatic exp_t model(input logic [31:0] pc);
        exp_t e;
        int k, maxb, w;
        bit sgn, bad;
        logic [127:0] acc;
        e.err  = 1'b0;
        e.code = 2'd0;
        e.op   = mem[pc[7:0]];
        e.imm  = 64'd0;
        e.nb   = 0;
        e.npc  = pc + 32'd1;
        k = kind_of(e.op);
        if (k == 5) begin
            e.err  = 1'b1;
            e.code = 2'd3;
            e.npc  = pc;
        end else if (k == 4) begin
            e.imm = {56'd0, mem[8'(pc + 32'd1)]};
            e.nb  = 1;
            e.npc = pc + 32'd2;
        end else if (k != 0) begin
            maxb = (k == 3) ? 10 : 5;
            w    = (k == 3) ? 64 : 32;
            sgn  = (k == 2) || (k == 3);
            acc  = '0;
            for (int i = 0; i < maxb; i++) begin
                logic [7:0] b;
                b = mem[8'(pc + 32'(i + 1))];
                acc = acc | (128'(b[6:0]) << (7 * i));
                e.nb = i + 1;
                if (b[7]) begin
                    if (i == maxb - 1) begin
                        e.err  = 1'b1;
                        e.code = 2'd1;
                        e.npc  = pc + 32'(e.nb);
                    end
                    continue;
                end
                bad = 1'b0;
                if (i == maxb - 1) begin
                    // the full encoding must fit in w bits
                    for (int j = w - (sgn ? 1 : 0); j < 7 * maxb; j++)
                        if (acc[j] !== (sgn ? acc[w-1] : 1'b0)) bad = 1'b1;
                end
                if (bad) begin
                    e.err  = 1'b1;
                    e.code = 2'd2;
                    e.npc  = pc + 32'(e.nb);
                end else begin
                    if (sgn && b[6] && 7 * (i + 1) < 64)
                        acc = acc | ~((128'd1 << (7 * (i + 1))) - 128'd1);
                    e.imm = acc[63:0];
                    e.npc = pc + 32'(1 + e.nb);
                end
                break;
            end
        end
        return e;
    endfunction

    task automatic load(input logic [31:0] pc, input logic [7:0] q[$]);
        foreach (q[i]) mem[8'(pc + 32'(i))] = q[i];
    endtask

    task automatic decode(input logic [31:0] pc, input string tag,
                          input bit chk_lat);
        exp_t e;
        int cyc;
        e = model(pc);
        @(negedge clk);
        start_pc = pc;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        check({tag, ".busy"}, {63'd0, busy}, 64'd1);
        while (!(done || error) && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, ".finish"}, {63'd0, done | error}, 64'd1);
        check({tag, ".error"}, {63'd0, error}, {63'd0, e.err});
        check({tag, ".opcode"}, {56'd0, opcode}, {56'd0, e.op});
        check({tag, ".imm_bytes"}, {60'd0, imm_bytes}, 64'(e.nb));
        check({tag, ".next_pc"}, {32'd0, next_pc}, {32'd0, e.npc});
        if (e.err)
            check({tag, ".err_code"}, {62'd0, err_code}, {62'd0, e.code});
        else
            check({tag, ".imm"}, imm, e.imm);
        if (chk_lat && !e.err)
            check({tag, ".latency"}, 64'(cyc),
                  64'((1 + e.nb) * (lat_fixed + 2) + 1));
        @(negedge clk);
        check({tag, ".pulse"}, {62'd0, done, error}, 64'd0);
        check({tag, ".idle"}, {62'd0, busy, mem_read_en}, 64'd0);
        check({tag, ".hold"}, {56'd0, opcode}, {56'd0, e.op});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];
        bit found;
        logic [7:0] ops [10];
        ops = '{8'h1A, 8'h41, 8'h42, 8'h10, 8'h20, 8'h02,
                8'h6A, 8'h05, 8'h0C, 8'h00};
        foreach (mem[i]) mem[i] = 8'h00;
        rst      = 1'b1;
        start    = 1'b0;
        start_pc = 32'd0;
        repeat (3) @(negedge clk);
        check("rst.flags", {59'd0, busy, done, error, mem_read_en, 1'b0}, 64'd0);
        check("rst.opcode", {56'd0, opcode}, 64'd0);
        check("rst.imm", imm, 64'd0);
        check("rst.imm_bytes", {60'd0, imm_bytes}, 64'd0);
        check("rst.next_pc", {32'd0, next_pc}, 64'd0);
        check("rst.err_code", {62'd0, err_code}, 64'd0);
        check("rst.mem_addr", {32'd0, mem_addr}, 64'd0);
        rst = 1'b0;

        lat_fixed = 0;
        q = '{8'h1A};
        load(32'h100, q);
        decode(32'h100, "t1", 1'b1);
        check("t1.next_pc_const", {32'd0, next_pc}, 64'h101);

        lat_fixed = 1;
        q = '{8'h41, 8'h7F};
        load(32'h110, q);
        decode(32'h110, "t2", 1'b1);
        check("t2.imm_const", imm, 64'hFFFF_FFFF_FFFF_FFFF);

        lat_fixed = 2;
        q = '{8'h10, 8'hE5, 8'h8E, 8'h26};
        load(32'h120, q);
        decode(32'h120, "t3", 1'b1);
        check("t3.imm_const", imm, 64'h98765);

        lat_fixed = 0;
        q = '{8'h42, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80,
              8'h80, 8'h80, 8'h80, 8'h80, 8'h7F};
        load(32'h130, q);
        decode(32'h130, "t4", 1'b1);
        check("t4.imm_const", imm, 64'h8000_0000_0000_0000);

        q = '{8'h20, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
        load(32'h150, q);
        decode(32'h150, "t5len", 1'b0);
        check("t5len.code_const", {62'd0, err_code}, 64'd1);

        q = '{8'h20, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h1F};
        load(32'h160, q);
        decode(32'h160, "t5ovf", 1'b0);
        check("t5ovf.code_const", {62'd0, err_code}, 64'd2);

        q = '{8'h02, 8'h40};
        load(32'h170, q);
        decode(32'h170, "bt", 1'b1);

        q = '{8'h05};
        load(32'h180, q);
        decode(32'h180, "unk", 1'b0);

        lat_fixed = 1;
        q = '{8'h41, 8'h80, 8'h7F};
        load(32'hFFFF_FFFE, q);
        decode(32'hFFFF_FFFE, "wrap", 1'b1);
        check("wrap.next_pc_const", {32'd0, next_pc}, 64'h1);

        // reset while the first immediate byte is being requested
        lat_fixed = 3;
        q = '{8'h10, 8'hE5, 8'h8E, 8'h26};
        load(32'h40, q);
        @(negedge clk);
        start_pc = 32'h40;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (mem_read_en && mem_addr == 32'h41) found = 1'b1;
            else @(negedge clk);
        end
        check("t6.reached_imm_req", {63'd0, found}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6.read_en", {63'd0, mem_read_en}, 64'd0);
        check("t6.busy", {63'd0, busy}, 64'd0);
        check("t6.pulses", {62'd0, done, error}, 64'd0);
        decode(32'h40, "t6again", 1'b1);

        rand_lat = 1'b1;
        for (int n = 0; n < 40; n++) begin
            logic [31:0] pc;
            int len;
            bit raw;
            pc  = $urandom;
            len = int'($urandom_range(1, 11));
            raw = ($urandom_range(0, 3) == 0);
            q = {};
            q.push_back(($urandom_range(0, 4) == 0) ? 8'($urandom)
                                                     : ops[$urandom_range(0, 9)]);
            for (int i = 0; i < 11; i++) begin
                logic [7:0] b;
                b = 8'($urandom);
                if (!raw) b[7] = (i < len - 1);
                q.push_back(b);
            end
            load(pc, q);
            decode(pc, "rnd", 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
